// File: rtl/bullet_control.sv
// Player bullet controller: spawns a bullet on a fire press, moves it up the
// screen on each tick, tests it against the enemy hitbox, and keeps score.
module bullet_control #(
  parameter logic [6:0] PLAYER_Y = 7'd112,
  parameter int         STEP     = 2,
  parameter int         ENEMY_W  = 8,
  parameter int         ENEMY_H  = 8,
  parameter int         COOLDOWN = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fire,
  input  logic       tick,
  input  logic [7:0] playerX,
  input  logic [7:0] enemyX,
  input  logic [6:0] enemyY,
  input  logic       enemyActive,
  output logic [7:0] bulletX,
  output logic [6:0] bulletY,
  output logic       bulletActive,
  output logic       collidedWithBullet,
  output logic [7:0] score,
  output logic       inUpdatePositionStateB
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_MOVE,
    S_HIT,
    S_COOLDOWN
  } state_t;

  state_t     r_state;
  logic       r_fire_q;
  logic       r_armed;
  logic [7:0] r_bulletX;
  logic [6:0] r_bulletY;
  logic [7:0] r_score;
  logic [7:0] r_cd_cnt;

  logic       w_fire_edge;
  logic [8:0] w_x_hi;
  logic [7:0] w_y_hi;
  logic       w_hit;
  logic       w_expire;

  // Score increments stop at full scale instead of wrapping to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    sat_inc = (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  // A fire level still held from before reset must be released once before
  // it can count as a press; r_armed records that release.
  assign w_fire_edge = fire & ~r_fire_q & r_armed;

  // Hitbox bounds are widened by one bit so an enemy near the right or
  // bottom edge cannot wrap around and match a bullet at the opposite edge.
  assign w_x_hi   = {1'b0, enemyX} + 9'(ENEMY_W - 1);
  assign w_y_hi   = {1'b0, enemyY} + 8'(ENEMY_H - 1);
  assign w_hit    = enemyActive
                  && (r_bulletX >= enemyX) && ({1'b0, r_bulletX} <= w_x_hi)
                  && (r_bulletY >= enemyY) && ({1'b0, r_bulletY} <= w_y_hi);
  assign w_expire = ({1'b0, r_bulletY} < 8'(STEP));

  // Bullet FSM with its position, score and cooldown registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_fire_q  <= 1'b0;
      r_armed   <= 1'b0;
      r_bulletX <= 8'd0;
      r_bulletY <= 7'd0;
      r_score   <= 8'd0;
      r_cd_cnt  <= 8'd0;
    end else begin
      r_fire_q <= fire;
      if (!fire) r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_fire_edge) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_bulletX <= playerX;
          r_bulletY <= PLAYER_Y;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (tick) r_state <= S_MOVE;
        end
        S_MOVE: begin
          // Hit is checked first so a bullet touching the enemy on its last
          // row still scores rather than expiring.
          if (w_hit) begin
            r_state <= S_HIT;
          end else if (w_expire) begin
            r_bulletY <= 7'd0;
            r_cd_cnt  <= 8'd0;
            r_state   <= S_COOLDOWN;
          end else begin
            r_bulletY <= r_bulletY - 7'(STEP);
            r_state   <= S_WAIT;
          end
        end
        S_HIT: begin
          // Held until a tick so enemy control sees the collision on its
          // own update strobe.
          if (tick) begin
            r_score  <= sat_inc(r_score);
            r_cd_cnt <= 8'd0;
            r_state  <= S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (tick) begin
            if (r_cd_cnt == 8'(COOLDOWN - 1)) r_state <= S_IDLE;
            else r_cd_cnt <= r_cd_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bulletX                = r_bulletX;
  assign bulletY                = r_bulletY;
  assign score                  = r_score;
  assign bulletActive           = (r_state == S_WAIT) || (r_state == S_MOVE)
                                || (r_state == S_HIT);
  assign collidedWithBullet     = (r_state == S_HIT);
  assign inUpdatePositionStateB = (r_state == S_MOVE);

endmodule

// File: tb/tb_bullet_control.sv
// Directed testbench for bullet_control.
module tb_bullet_control;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       fire = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] playerX = 8'd0;
  logic [7:0] enemyX = 8'd0;
  logic [6:0] enemyY = 7'd0;
  logic       enemyActive = 1'b0;
  logic [7:0] bulletX;
  logic [6:0] bulletY;
  logic       bulletActive;
  logic       collidedWithBullet;
  logic [7:0] score;
  logic       inUpdatePositionStateB;

  int   errors = 0;
  int   checks = 0;
  logic upd_seen = 1'b0;

  bullet_control dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .fire                   (fire),
    .tick                   (tick),
    .playerX                (playerX),
    .enemyX                 (enemyX),
    .enemyY                 (enemyY),
    .enemyActive            (enemyActive),
    .bulletX                (bulletX),
    .bulletY                (bulletY),
    .bulletActive           (bulletActive),
    .collidedWithBullet     (collidedWithBullet),
    .score                  (score),
    .inUpdatePositionStateB (inUpdatePositionStateB)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One tick strobe, then let the move cycle complete.
  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    upd_seen = inUpdatePositionStateB;
    step();
    step();
  endtask

  // Single fire press; leaves the bullet in its wait state at the spawn row.
  task automatic press();
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
  endtask

  // Bullet spawned inside an enemy at the spawn row: hit on first move.
  task automatic fast_hit();
    playerX = 8'd44;
    enemyX = 8'd40;
    enemyY = 7'd106;
    enemyActive = 1'b1;
    press();
    do_tick();
    do_tick();
    repeat (4) do_tick();
  endtask

  // Hitbox-edge shot at the spawn row; a miss is flown out to cooldown end.
  task automatic shot(input string tag, input logic [7:0] px, input logic [7:0] ex,
                      input logic exp_hit);
    playerX = px;
    enemyX = ex;
    enemyY = 7'd106;
    enemyActive = 1'b1;
    press();
    do_tick();
    chk(tag, collidedWithBullet, exp_hit);
    if (exp_hit) begin
      do_tick();
      repeat (4) do_tick();
    end else begin
      repeat (60) do_tick();
    end
  endtask

  initial begin
    // Reset with fire already held high
    fire = 1'b1;
    playerX = 8'd40;
    repeat (3) step();
    chk("rst_bulletX", bulletX, 0);
    chk("rst_bulletY", bulletY, 0);
    chk("rst_active", bulletActive, 0);
    chk("rst_collided", collidedWithBullet, 0);
    chk("rst_score", score, 0);
    chk("rst_upd", inUpdatePositionStateB, 0);
    resetn = 1'b1;
    repeat (4) step();
    chk("held_fire_after_reset", bulletActive, 0);
    fire = 1'b0;
    step();

    // Free flight with fire held throughout flight and cooldown
    fire = 1'b1;
    step();
    step();
    chk("spawn_active", bulletActive, 1);
    chk("spawn_x", bulletX, 40);
    chk("spawn_y", bulletY, 112);
    for (int k = 1; k <= 56; k++) begin
      do_tick();
      chk("flight_y", bulletY, 112 - 2 * k);
    end
    chk("move_strobe", upd_seen, 1);
    chk("strobe_low_in_wait", inUpdatePositionStateB, 0);
    chk("active_at_row0", bulletActive, 1);
    do_tick();
    chk("expire_active", bulletActive, 0);
    chk("expire_y", bulletY, 0);
    chk("expire_score", score, 0);
    repeat (4) do_tick();
    repeat (5) step();
    chk("no_retrigger", bulletActive, 0);
    fire = 1'b0;
    step();

    // Second press: bullet climbs into enemy at (40,60)
    playerX = 8'd44;
    enemyX = 8'd40;
    enemyY = 7'd60;
    enemyActive = 1'b1;
    press();
    chk("second_bullet", bulletActive, 1);
    chk("second_x", bulletX, 44);
    repeat (23) do_tick();
    chk("pre_hit_y", bulletY, 66);
    chk("pre_hit_coll", collidedWithBullet, 0);
    do_tick();
    chk("hit_coll", collidedWithBullet, 1);
    chk("hit_y_held", bulletY, 66);
    chk("hit_active", bulletActive, 1);
    repeat (3) step();
    chk("hit_coll_hold", collidedWithBullet, 1);
    chk("hit_score_before_tick", score, 0);
    tick = 1'b1;
    #1;
    chk("hit_coll_tick_cycle", collidedWithBullet, 1);
    step();
    tick = 1'b0;
    chk("post_hit_coll", collidedWithBullet, 0);
    chk("post_hit_score", score, 1);
    chk("post_hit_active", bulletActive, 0);
    step();
    repeat (3) do_tick();
    press();
    chk("fire_in_cooldown_ignored", bulletActive, 0);
    do_tick();
    press();
    chk("fire_after_cooldown", bulletActive, 1);

    // Same bullet against an inactive enemy overlapping it: no hit
    enemyActive = 1'b0;
    enemyY = 7'd106;
    do_tick();
    chk("inactive_enemy_coll", collidedWithBullet, 0);
    chk("inactive_enemy_y", bulletY, 110);
    repeat (60) do_tick();

    // Hitbox edges
    shot("edge_x47_hit", 8'd47, 8'd40, 1'b1);
    shot("edge_x48_miss", 8'd48, 8'd40, 1'b0);
    shot("edge_x255_hit", 8'd255, 8'd250, 1'b1);
    shot("edge_x2_nowrap", 8'd2, 8'd250, 1'b0);
    chk("score_after_edges", score, 3);

    // Enemy drops out while the hit is pending
    playerX = 8'd44;
    enemyX = 8'd40;
    enemyY = 7'd106;
    enemyActive = 1'b1;
    press();
    do_tick();
    chk("drop_hit_coll", collidedWithBullet, 1);
    enemyActive = 1'b0;
    repeat (3) step();
    chk("drop_coll_hold", collidedWithBullet, 1);
    do_tick();
    chk("drop_score", score, 4);
    chk("drop_coll_clear", collidedWithBullet, 0);
    repeat (4) do_tick();
    fast_hit();
    chk("score_five", score, 5);

    // Reset mid-flight at row 80
    enemyActive = 1'b0;
    press();
    repeat (16) do_tick();
    chk("midflight_y", bulletY, 80);
    resetn = 1'b0;
    step();
    chk("mid_rst_x", bulletX, 0);
    chk("mid_rst_y", bulletY, 0);
    chk("mid_rst_active", bulletActive, 0);
    chk("mid_rst_coll", collidedWithBullet, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_upd", inUpdatePositionStateB, 0);
    resetn = 1'b1;
    step();

    // Score saturation
    repeat (254) fast_hit();
    chk("score_254", score, 254);
    fast_hit();
    chk("score_255", score, 255);
    fast_hit();
    chk("score_sat", score, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bullet_control.md
BULLET_CONTROL -- requirements
Module: bullet_control

Interface
REQ-001 SHALL have parameter PLAYER_Y, default 7'd112: bullet spawn row.
REQ-002 SHALL have parameter STEP, default 2: rows moved per tick.
REQ-003 SHALL have parameter ENEMY_W, default 8: enemy hitbox width in pixels.
REQ-004 SHALL have parameter ENEMY_H, default 8: enemy hitbox height in pixels.
REQ-005 SHALL have parameter COOLDOWN, default 4: ticks between bullets.
REQ-006 SHALL have port clk  in  1: clock, all state updates on posedge.
REQ-007 SHALL have port resetn  in  1: synchronous, active-low reset.
REQ-008 SHALL have port fire  in  1: level fire button.
REQ-009 SHALL have port tick  in  1: single-cycle position-update strobe, shared with enemy control.
REQ-010 SHALL have port playerX  in  8: player column.
REQ-011 SHALL have port enemyX  in  8: enemy left column.
REQ-012 SHALL have port enemyY  in  7: enemy top row.
REQ-013 SHALL have port enemyActive  in  1: high when enemy is live, i.e. not in its reset state.
REQ-014 SHALL have port bulletX  out  8: bullet column.
REQ-015 SHALL have port bulletY  out  7: bullet row; 0 is the screen top.
REQ-016 SHALL have port bulletActive  out  1: bullet is drawn.
REQ-017 SHALL have port collidedWithBullet  out  1: hit indication to enemy control.
REQ-018 SHALL have port score  out  8: hit count.
REQ-019 SHALL have port inUpdatePositionStateB  out  1: high in S_MOVE, used as the draw/erase strobe.

Function
REQ-020 SHALL register fire each cycle into fire_q; fireEdge = fire & ~fire_q.
REQ-021 SHALL implement states S_IDLE, S_LOAD, S_WAIT, S_MOVE, S_HIT, S_COOLDOWN.
REQ-022 S_IDLE: fireEdge -> S_LOAD; else stay; bulletActive=0.
REQ-023 S_LOAD, one cycle: bulletX<=playerX; bulletY<=PLAYER_Y; -> S_WAIT; a tick in this cycle is dropped.
REQ-024 S_WAIT: tick -> S_MOVE; else stay; bulletActive=1.
REQ-025 S_MOVE, one cycle, bulletActive=1, inUpdatePositionStateB=1; hit test uses the pre-move bulletX/bulletY.
REQ-026 Hit condition: enemyActive & enemyX<=bulletX<=enemyX+ENEMY_W-1 & enemyY<=bulletY<=enemyY+ENEMY_H-1, with sums computed 9/8 bits wide (no wrap).
REQ-027 S_MOVE, hit: -> S_HIT; bulletY unchanged.
REQ-028 S_MOVE, no hit, bulletY<STEP: expire -> S_COOLDOWN; bulletY<=0.
REQ-029 S_MOVE, otherwise: bulletY<=bulletY-STEP -> S_WAIT.
REQ-030 Hit SHALL take priority over expiry in the same cycle.
REQ-031 S_HIT: collidedWithBullet=1 and bulletActive=1 on every cycle in this state.
REQ-032 S_HIT holds until a cycle with tick=1, guaranteeing overlap with the enemy's update strobe.
REQ-033 In that S_HIT tick cycle: score increments, saturating at 8'd255; -> S_COOLDOWN.
REQ-034 S_COOLDOWN: bulletActive=0; a tick counter loads 0 on entry and increments per tick; at COOLDOWN ticks -> S_IDLE.
REQ-035 collidedWithBullet SHALL be 0 in every state except S_HIT.
REQ-036 fireEdge outside S_IDLE SHALL be ignored and not queued; a held fire never retriggers.
REQ-037 If enemyActive drops while in S_HIT, stay in S_HIT until tick; score still increments.
REQ-038 Outputs SHALL be registered or decoded from state only, with no combinational path from the inputs.

Reset
REQ-039 resetn=0 at a clock edge SHALL force S_IDLE in any state, including mid-flight.
REQ-040 Reset values: bulletX=0, bulletY=0, bulletActive=0, collidedWithBullet=0, score=0, inUpdatePositionStateB=0, fire_q=0, cooldown counter=0.
REQ-041 After reset, a fire level already high SHALL NOT fire until it is released and pressed again.

Verification
REQ-042 Free flight: playerX=40, no enemy, press fire, 56 ticks -> bulletY 112,110,...,2,0, then expire, bulletActive=0, score=0.
REQ-043 Hit: enemy at (40,60), playerX=44 -> hit detected when bulletY=66; collidedWithBullet high until next tick and high in that tick cycle; score 0->1; S_IDLE after 4 further ticks.
REQ-044 Edge of hitbox: bulletX=47 and enemyX=40 hit; bulletX=48 miss; enemyX=250 with bulletX=255 hits, no wrap false-hit at bulletX=2.
REQ-045 Retrigger: fire held high through flight and cooldown -> exactly one bullet; release and press -> second bullet.
REQ-046 Reset mid-flight at bulletY=80 -> next cycle all outputs at reset values; score cleared from 5 to 0.
REQ-047 Saturation: preload 254 hits, two more hits -> score 255 and stays 255.
